// File: rtl/buzz_sched.sv
// buzz_sched: fixed-priority sequencer for the single piezo buzzer.
// Grants one of three requesters (alarm, chime, key click) and plays its
// burst of beeps, each beep being an ON phase with a square-wave tone
// followed by a silent OFF phase.
// Optional feature: define BUZZ_PREEMPT_EN to let a higher-priority request
// abort a running lower-priority sequence.
module buzz_sched #(
  parameter int ON_CYC    = 50_000_000,
  parameter int OFF_CYC   = 50_000_000,
  parameter int TONE_HALF = 25_000,
  parameter int TW        = 27,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  output logic [2:0]    grant,
  output logic [2:0]    ack,
  output logic          busy,
  output logic          buzz_out
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [TW-1:0] tone_cnt, tone_nxt;
  logic [CW-1:0] rem, rem_nxt;
  logic [2:0]    grant_nxt, ack_nxt;
  logic          busy_nxt, buzz_nxt;
  logic [2:0]    sel_grant;
  logic [CW-1:0] sel_cnt;
  logic          withdrawn, preempt, abort;

  // The owner dropping its request always ends the sequence silently.
  assign withdrawn = ~|(req & grant);

`ifdef BUZZ_PREEMPT_EN
  // grant is one-hot, so grant-1 masks every higher-priority (lower) index.
  assign preempt = |(req & (grant - 3'b001));
`else
  assign preempt = 1'b0;
`endif

  assign abort = withdrawn | preempt;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    tone_nxt  = tone_cnt;
    rem_nxt   = rem;
    grant_nxt = grant;
    ack_nxt   = 3'b000;
    buzz_nxt  = buzz_out;
    sel_grant = 3'b000;
    sel_cnt   = '0;
    if (req[0]) begin
      sel_grant = 3'b001;
      sel_cnt   = cnt0;
    end else if (req[1]) begin
      sel_grant = 3'b010;
      sel_cnt   = cnt1;
    end else if (req[2]) begin
      sel_grant = 3'b100;
      sel_cnt   = cnt2;
    end
    case (state)
      S_IDLE: begin
        grant_nxt = 3'b000;
        buzz_nxt  = 1'b0;
        if (sel_grant != 3'b000) begin
          grant_nxt = sel_grant;
          rem_nxt   = sel_cnt;
          timer_nxt = '0;
          tone_nxt  = '0;
          if (sel_cnt == '0) begin
            state_nxt = S_DONE;
            ack_nxt   = sel_grant;
          end else begin
            state_nxt = S_ON;
            buzz_nxt  = 1'b1;
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_nxt = S_IDLE;
          grant_nxt = 3'b000;
          buzz_nxt  = 1'b0;
          timer_nxt = '0;
          tone_nxt  = '0;
          rem_nxt   = '0;
        end else if (timer == ON_LAST) begin
          state_nxt = S_OFF;
          timer_nxt = '0;
          buzz_nxt  = 1'b0;
          if (rem != '0) rem_nxt = rem - CW'(1);
        end else begin
          timer_nxt = timer + TW'(1);
          if (tone_cnt == TONE_LAST) begin
            tone_nxt = '0;
            buzz_nxt = ~buzz_out;
          end else begin
            tone_nxt = tone_cnt + TW'(1);
          end
        end
      end
      S_OFF: begin
        buzz_nxt = 1'b0;
        if (abort) begin
          state_nxt = S_IDLE;
          grant_nxt = 3'b000;
          timer_nxt = '0;
          tone_nxt  = '0;
          rem_nxt   = '0;
        end else if (timer == OFF_LAST) begin
          timer_nxt = '0;
          if (rem == '0) begin
            state_nxt = S_DONE;
            ack_nxt   = grant;
          end else begin
            state_nxt = S_ON;
            tone_nxt  = '0;
            buzz_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        grant_nxt = 3'b000;
        buzz_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 3'b000;
        buzz_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, timers and registered outputs; reset aborts silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      tone_cnt <= '0;
      rem      <= '0;
      grant    <= 3'b000;
      ack      <= 3'b000;
      busy     <= 1'b0;
      buzz_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tone_cnt <= tone_nxt;
      rem      <= rem_nxt;
      grant    <= grant_nxt;
      ack      <= ack_nxt;
      busy     <= busy_nxt;
      buzz_out <= buzz_nxt;
    end
  end

endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: directed scenarios plus randomized traffic for buzz_sched,
// checked against a sequence-position model of the beep schedule.
module tb_buzz_sched;

  localparam int ON_CYC    = 4;
  localparam int OFF_CYC   = 3;
  localparam int TONE_HALF = 2;
  localparam int TW        = 8;
  localparam int CW        = 4;
  localparam int PER       = ON_CYC + OFF_CYC;
`ifdef BUZZ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [CW-1:0] cnt0, cnt1, cnt2;
  logic [2:0]    grant, ack;
  logic          busy, buzz_out;

  int vectors = 0;
  int errors  = 0;

  // Model: whether a sequence is running, its owner, beep count and the
  // cycle position within it (0 = first ON cycle, n*PER = DONE cycle).
  bit m_active = 1'b0;
  int m_owner  = 0;
  int m_n      = 0;
  int m_t      = 0;

  buzz_sched #(
    .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .TONE_HALF(TONE_HALF), .TW(TW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
    .grant(grant), .ack(ack), .busy(busy), .buzz_out(buzz_out)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then move 1 time unit past the edge for sampling.
  task automatic step();
    logic [2:0] higher;
    @(posedge clk);
    if (!rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (req != 3'b000) begin
        m_owner  = req[0] ? 0 : (req[1] ? 1 : 2);
        m_n      = (m_owner == 0) ? int'(cnt0) : (m_owner == 1) ? int'(cnt1) : int'(cnt2);
        m_t      = 0;
        m_active = 1'b1;
      end
    end else if (m_t == m_n * PER) begin
      m_active = 1'b0;
    end else begin
      higher = (3'b001 << m_owner) - 3'b001;
      if (!req[m_owner] || (PREEMPT && ((req & higher) != 3'b000)))
        m_active = 1'b0;
      else
        m_t++;
    end
    #1;
  endtask

  // Expected outputs {grant, ack, busy, buzz_out} derived from the position.
  function automatic logic [7:0] model_out();
    logic [2:0] g, a;
    logic       bz;
    int         p;
    if (!m_active) return 8'h00;
    g  = 3'b001 << m_owner;
    a  = (m_t == m_n * PER) ? g : 3'b000;
    p  = m_t % PER;
    bz = (m_t < m_n * PER) && (p < ON_CYC) && (((p / TONE_HALF) % 2) == 0);
    return {g, a, 1'b1, bz};
  endfunction

  task automatic settle();
    req = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b0; req = 3'b000; cnt0 = '0; cnt1 = '0; cnt2 = '0;
    repeat (2) step();
    vectors++;
    if ({grant, ack, busy, buzz_out} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b required 00000000", {grant, ack, busy, buzz_out});
    end
    rst = 1'b1;
    step();
    req = 3'b010; cnt1 = 4'd3;
    repeat (2) step();
    vectors++;
    if ({grant, busy, buzz_out} !== 5'b01011) begin
      errors++;
      $display("[TB] FAIL reset_pre_on: got %b required 01011", {grant, busy, buzz_out});
    end
    #2 rst = 1'b0;
    m_active = 1'b0;
    #1;
    vectors++;
    if ({grant, ack, busy, buzz_out} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b required 00000000", {grant, ack, busy, buzz_out});
    end
    req = 3'b000;
    step();
    rst = 1'b1;
    repeat (4) begin
      step();
      e = model_out();
      vectors++;
      if ({grant, ack, busy, buzz_out} !== e) begin
        errors++;
        $display("[TB] FAIL reset_release: got %b required %b", {grant, ack, busy, buzz_out}, e);
      end
    end
  endtask

  task automatic test_single_burst();
    logic [6:0] pat;
    pat = 7'b1100000;
    req = 3'b010; cnt1 = 4'd2;
    for (int i = 0; i < 15; i++) begin
      step();
      vectors++;
      if (grant !== 3'b010 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL burst_grant[%0d]: got %b/%b required 010/1", i, grant, busy);
      end
      vectors++;
      if (i < 14 && buzz_out !== pat[6 - (i % PER)]) begin
        errors++;
        $display("[TB] FAIL burst_buzz[%0d]: got %b required %b", i, buzz_out, pat[6 - (i % PER)]);
      end
      vectors++;
      if (ack !== ((i == 14) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("[TB] FAIL burst_ack[%0d]: got %b required %b", i, ack, (i == 14) ? 3'b010 : 3'b000);
      end
    end
    req = 3'b000;
    step();
    vectors++;
    if ({grant, ack, busy, buzz_out} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL burst_end: got %b required 00000000", {grant, ack, busy, buzz_out});
    end
    settle();
  endtask

  task automatic test_priority();
    logic [7:0] e;
    req = 3'b101; cnt0 = 4'd1; cnt2 = 4'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (grant !== 3'b001 || ack !== ((i == 7) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("[TB] FAIL prio_alarm[%0d]: got grant %b ack %b", i, grant, ack);
      end
    end
    req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      step();
      e = model_out();
      vectors++;
      if ({grant, ack, busy, buzz_out} !== e) begin
        errors++;
        $display("[TB] FAIL prio_click[%0d]: got %b required %b", i, {grant, ack, busy, buzz_out}, e);
      end
      if (i == 1) begin
        vectors++;
        if (grant !== 3'b100) begin
          errors++;
          $display("[TB] FAIL prio_regrant: got %b required 100", grant);
        end
      end
    end
    settle();
  endtask

  task automatic test_zero_count();
    req = 3'b100; cnt2 = 4'd0;
    step();
    vectors++;
    if (ack !== 3'b100 || buzz_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_ack: got ack %b buzz %b busy %b required 100/0/1", ack, buzz_out, busy);
    end
    req = 3'b000;
    repeat (2) begin
      step();
      vectors++;
      if (ack !== 3'b000 || buzz_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_after: got ack %b buzz %b required 000/0", ack, buzz_out);
      end
    end
    settle();
  endtask

  task automatic test_withdrawal();
    req = 3'b010; cnt1 = 4'd3;
    repeat (2) step();
    req = 3'b000;
    step();
    vectors++;
    if (buzz_out !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("[TB] FAIL withdraw: got buzz %b grant %b required 0/000", buzz_out, grant);
    end
    repeat (10) begin
      step();
      vectors++;
      if (ack !== 3'b000) begin
        errors++;
        $display("[TB] FAIL withdraw_ack: got %b required 000", ack);
      end
    end
  endtask

  task automatic test_preempt();
    logic [7:0] e;
    int ack_at, g_at;
    ack_at = -1; g_at = -1;
    req = 3'b100; cnt2 = 4'd2; cnt0 = 4'd1;
    repeat (2) step();
    req = 3'b101;
    for (int i = 0; i < 40; i++) begin
      step();
      e = model_out();
      vectors++;
      if ({grant, ack, busy, buzz_out} !== e) begin
        errors++;
        $display("[TB] FAIL preempt_seq[%0d]: got %b required %b", i, {grant, ack, busy, buzz_out}, e);
      end
      if (ack == 3'b100 && ack_at < 0) begin
        ack_at = i;
        req[2] = 1'b0;
      end
      if (grant == 3'b001 && g_at < 0) g_at = i;
    end
    vectors++;
    if (PREEMPT) begin
      if (g_at != 1 || ack_at != -1) begin
        errors++;
        $display("[TB] FAIL preempt_on: got grant001 at %0d ack100 at %0d required 1/-1", g_at, ack_at);
      end
    end else begin
      if (ack_at < 0 || g_at <= ack_at) begin
        errors++;
        $display("[TB] FAIL preempt_off: got grant001 at %0d ack100 at %0d required grant after ack", g_at, ack_at);
      end
    end
    settle();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (!req[b]) begin
          if ($urandom_range(7) == 0) begin
            req[b] = 1'b1;
            case (b)
              0: cnt0 = CW'($urandom_range(3));
              1: cnt1 = CW'($urandom_range(3));
              default: cnt2 = CW'($urandom_range(3));
            endcase
          end
        end else if (ack[b] && $urandom_range(3) != 0) begin
          req[b] = 1'b0;
        end else if ($urandom_range(63) == 0) begin
          req[b] = 1'b0;
        end
      end
      step();
      e = model_out();
      vectors++;
      if ({grant, ack, busy, buzz_out} !== e) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %b required %b (req %b)", i, {grant, ack, busy, buzz_out}, e, req);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_priority();
    test_zero_count();
    test_withdrawal();
    test_preempt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
